aes_block_loader: RTL

//  Upstream feeder for AES_top. Assembles 32-bit words from a valid/ready stream into the
//  128-bit AES_data_in and AES_key_in vectors, then drives AES_en high and holds both

---
 rtl/aes_loader_pkg.sv | 8 +
 rtl/aes_word_assembler.sv | 29 ++
 rtl/aes_block_loader.sv | 88 ++++++++
 3 files changed

// File: rtl/aes_loader_pkg.sv
// aes_loader_pkg: shared state type and word/block geometry for the AES block loader
package aes_loader_pkg;
  typedef enum logic [1:0] {LOAD, RUN, GAP} state_e;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W = 32;
  localparam int BLOCK_W = WORDS_PER_BLOCK * WORD_W;
  localparam int WCNT_W = $clog2(WORDS_PER_BLOCK);
endpackage

// File: rtl/aes_word_assembler.sv
// aes_word_assembler: shifts 32-bit words into a 128-bit vector, flags a complete block
module aes_word_assembler
  import aes_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_i,
  input  logic               clr_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic [BLOCK_W-1:0] vec_o,
  output logic               full_o,
  output logic               fill_o
);
  logic [WCNT_W-1:0] cnt_q;
  logic              full_d;
  assign fill_o = shift_i & (cnt_q == WCNT_W'(WORDS_PER_BLOCK - 1));
  // the first word of a new group invalidates the previous block
  always_comb full_d = clr_i ? 1'b0 : fill_o ? 1'b1 : (shift_i && cnt_q == '0) ? 1'b0 : full_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec_o  <= '0;
      cnt_q  <= '0;
      full_o <= 1'b0;
    end else begin
      vec_o  <= shift_i ? {vec_o[BLOCK_W-WORD_W-1:0], word_i} : vec_o;
      cnt_q  <= clr_i ? '0 : shift_i ? cnt_q + 1'b1 : cnt_q;
      full_o <= full_d;
    end
endmodule

// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles key/data words and sequences AES_en handshakes with AES_top
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 16
) (
  input  logic               AES_clk,
  input  logic               AES_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_key,
  input  logic [WORD_W-1:0]  in_word,
  output logic               AES_en,
  output logic [BLOCK_W-1:0] AES_data_in,
  output logic [BLOCK_W-1:0] AES_key_in,
  input  logic               AES_data_out_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_count,
  output logic               err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_e        state_q;
  logic [TW-1:0] tmo_q;
  logic          hs, data_shift, key_shift;
  logic          data_full, data_fill, key_valid, key_fill, go;
  assign in_ready   = (state_q == LOAD) & ~(data_full & ~in_key);
  assign hs         = in_valid & in_ready;
  assign data_shift = hs & ~in_key;
  assign key_shift  = hs & in_key;
  // key_valid implies the key count has wrapped, so any key word now restarts the key
  assign go = (data_full | data_fill) & (key_fill | (key_valid & ~key_shift));
  aes_word_assembler u_data (
    .clk     (AES_clk),
    .rst_n   (AES_rst_n),
    .shift_i (data_shift),
    .clr_i   (state_q == GAP),
    .word_i  (in_word),
    .vec_o   (AES_data_in),
    .full_o  (data_full),
    .fill_o  (data_fill)
  );
  aes_word_assembler u_key (
    .clk     (AES_clk),
    .rst_n   (AES_rst_n),
    .shift_i (key_shift),
    .clr_i   (1'b0),
    .word_i  (in_word),
    .vec_o   (AES_key_in),
    .full_o  (key_valid),
    .fill_o  (key_fill)
  );
  always_ff @(posedge AES_clk or negedge AES_rst_n)
    if (!AES_rst_n) begin
      state_q     <= LOAD;
      tmo_q       <= '0;
      AES_en      <= 1'b0;
      busy        <= 1'b0;
      blk_count   <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state_q)
        LOAD: if (go) begin
          state_q <= RUN;
          AES_en  <= 1'b1;
          busy    <= 1'b1;
          tmo_q   <= '0;
        end
        RUN: begin
          tmo_q <= tmo_q + 1'b1;
          if (AES_data_out_valid) begin
            state_q   <= GAP;
            AES_en    <= 1'b0;
            blk_count <= blk_count + 1'b1;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= GAP;
            AES_en      <= 1'b0;
            err_timeout <= 1'b1;
          end
        end
        GAP: begin
          state_q <= LOAD;
          busy    <= 1'b0;
        end
        default: state_q <= LOAD;
      endcase
    end
endmodule
